// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg
//   Shared types and constants for the decode stage: register-address and
//   word types, fetch/decode bundle structs, the decoder control word with
//   its op encodings, the RV opcode constants and the decoder function.
package decode_stage_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int DEPTH_DEF = 2;
  localparam int NBYP_DEF  = 2;

  typedef logic [XLEN_DEF-1:0] word_t;
  typedef logic [4:0]          creg_addr_t;

  // OP_ILLEGAL is the all-zero encoding so a reset control word decodes as "nothing".
  typedef enum logic [2:0] {
    OP_ILLEGAL = 3'd0,
    OP_RTYPE   = 3'd1,
    OP_ITYPE   = 3'd2,
    OP_STYPE   = 3'd3,
    OP_BTYPE   = 3'd4,
    OP_UTYPE   = 3'd5,
    OP_JTYPE   = 3'd6
  } op_e;

  localparam logic [6:0] OPC_LOAD    = 7'h03;
  localparam logic [6:0] OPC_OPIMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC   = 7'h17;
  localparam logic [6:0] OPC_OPIMM32 = 7'h1b;
  localparam logic [6:0] OPC_STORE   = 7'h23;
  localparam logic [6:0] OPC_OP      = 7'h33;
  localparam logic [6:0] OPC_LUI     = 7'h37;
  localparam logic [6:0] OPC_OP32    = 7'h3b;
  localparam logic [6:0] OPC_BRANCH  = 7'h63;
  localparam logic [6:0] OPC_JALR    = 7'h67;
  localparam logic [6:0] OPC_JAL     = 7'h6f;

  typedef struct packed {
    op_e        op;
    logic [2:0] funct3;
    logic       alt;        // SUB/SRA select
    logic       use_rs1;
    logic       use_rs2;
    logic       reg_write;
  } control_t;

  typedef struct packed {
    word_t       pc;
    logic [31:0] instr;
  } fetch_data_t;

  typedef struct packed {
    word_t       pc;
    word_t       srca;
    word_t       srcb;
    logic [31:0] instr;
    creg_addr_t  rd;
    control_t    ctl;
  } decode_data_t;

  function automatic control_t decode(input logic [31:0] instr);
    control_t c;
    c        = '0;
    c.op     = OP_ILLEGAL;
    c.funct3 = instr[14:12];
    case (instr[6:0])
      OPC_OP, OPC_OP32: begin
        c.op        = OP_RTYPE;
        c.alt       = instr[30];
        c.use_rs1   = 1'b1;
        c.use_rs2   = 1'b1;
        c.reg_write = 1'b1;
      end
      OPC_OPIMM, OPC_OPIMM32, OPC_LOAD, OPC_JALR: begin
        c.op        = OP_ITYPE;
        c.alt       = (instr[6:0] == OPC_OPIMM || instr[6:0] == OPC_OPIMM32)
                      && instr[14:12] == 3'b101 && instr[30];
        c.use_rs1   = 1'b1;
        c.reg_write = 1'b1;
      end
      OPC_STORE: begin
        c.op      = OP_STYPE;
        c.use_rs1 = 1'b1;
        c.use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        c.op      = OP_BTYPE;
        c.use_rs1 = 1'b1;
        c.use_rs2 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        c.op        = OP_UTYPE;
        c.reg_write = 1'b1;
      end
      OPC_JAL: begin
        c.op        = OP_JTYPE;
        c.reg_write = 1'b1;
      end
      default: c.op = OP_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if
//   Fetch-to-decode and decode-to-execute handshake bundle.
//   in_*  : fetch offers pc/instruction (in_valid/in_ready)
//   out_* : decoded bundle toward execute (out_valid/out_ready)
//   Modports: master = environment side, slave = decode stage side.
interface decode_stage_if #(
  parameter int XLEN = decode_stage_pkg::XLEN_DEF
) ();
  import decode_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [31:0]       in_instr;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_srca;
  logic [XLEN-1:0]   out_srcb;
  logic [31:0]       out_instr;
  creg_addr_t        out_rd;
  control_t          out_ctl;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_srca, out_srcb, out_instr, out_rd, out_ctl
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_srca, out_srcb, out_instr, out_rd, out_ctl
  );

endinterface

// File: rtl/decode_stage_ibuf.sv
// ibuf
//   Instruction buffer: DEPTH-entry FIFO of W-bit words (pc+instr).
//   Ports: clk, resetn (async active-low), flush (empties, beats push/pop),
//   push/push_data (ignored when full), pop (ignored when empty),
//   head_data (oldest entry), empty, full.
module ibuf #(
  parameter int W     = 96,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         empty,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head_data is only consumed while count_q != 0.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
//   Buffers fetched instructions, decodes the buffer head, reads operands
//   from the regfile or the bypass network and issues a registered bundle
//   to execute.
//   Ports: clk, resetn (async active-low); io (decode_stage_if.slave:
//   in_* fetch handshake, out_* execute handshake); rs1/rs2 regfile read
//   addresses with rd1/rd2 combinational read data; byp_valid/byp_rd/
//   byp_data/byp_pending bypass sources (index 0 youngest, highest
//   priority); flush discards everything held.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NBYP  = NBYP_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  decode_stage_if.slave        io,
  output creg_addr_t           rs1,
  output creg_addr_t           rs2,
  input  logic [XLEN-1:0]      rd1,
  input  logic [XLEN-1:0]      rd2,
  input  logic [NBYP-1:0]      byp_valid,
  input  logic [NBYP*5-1:0]    byp_rd,
  input  logic [NBYP*XLEN-1:0] byp_data,
  input  logic [NBYP-1:0]      byp_pending,
  input  logic                 flush
);

  localparam int FW = XLEN + 32;

  logic [FW-1:0]   head_data;
  logic            head_empty;
  logic            head_valid;
  logic            buf_full;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;
  control_t        head_ctl;

  logic [XLEN-1:0] srca, srcb;
  logic            pend_a, pend_b;
  logic            hit_a, hit_b;
  logic            hazard;
  logic            issue;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q,    out_pc_d;
  logic [XLEN-1:0] out_srca_q,  out_srca_d;
  logic [XLEN-1:0] out_srcb_q,  out_srcb_d;
  logic [31:0]     out_instr_q, out_instr_d;
  creg_addr_t      out_rd_q,    out_rd_d;
  control_t        out_ctl_q,   out_ctl_d;

  ibuf #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_ibuf (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .push      (io.in_valid),
    .push_data ({io.in_pc, io.in_instr}),
    .pop       (issue),
    .head_data (head_data),
    .empty     (head_empty),
    .full      (buf_full)
  );

  assign io.in_ready = !buf_full;
  assign head_valid  = !head_empty;
  assign head_pc     = head_data[FW-1:32];
  assign head_instr  = head_data[31:0];
  assign head_ctl    = decode(head_instr);

  always_comb begin
    rs1 = '0;
    rs2 = '0;
    if (head_valid) begin
      rs1 = head_instr[19:15];
      rs2 = (head_ctl.op == OP_ITYPE) ? '0 : head_instr[24:20];
    end
  end

  // Operand select: x0 reads zero and never stalls; otherwise the first
  // (lowest-index) live bypass naming the register wins over the regfile.
  always_comb begin
    srca   = '0;
    srcb   = '0;
    pend_a = 1'b0;
    pend_b = 1'b0;
    hit_a  = 1'b0;
    hit_b  = 1'b0;
    if (rs1 != '0) begin
      srca = rd1;
      for (int unsigned i = 0; i < NBYP; i++) begin
        if (!hit_a && byp_valid[i] && byp_rd[i*5 +: 5] == rs1) begin
          hit_a  = 1'b1;
          srca   = byp_data[i*XLEN +: XLEN];
          pend_a = byp_pending[i];
        end
      end
    end
    if (rs2 != '0) begin
      srcb = rd2;
      for (int unsigned i = 0; i < NBYP; i++) begin
        if (!hit_b && byp_valid[i] && byp_rd[i*5 +: 5] == rs2) begin
          hit_b  = 1'b1;
          srcb   = byp_data[i*XLEN +: XLEN];
          pend_b = byp_pending[i];
        end
      end
    end
  end

  assign hazard = head_valid && ((head_ctl.use_rs1 && pend_a) || (head_ctl.use_rs2 && pend_b));
  assign issue  = head_valid && !hazard && (!out_valid_q || io.out_ready) && !flush;

  // Data fields change only on issue, so a stalled bundle stays stable and
  // a flushed one just loses its valid.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_srca_d  = out_srca_q;
    out_srcb_d  = out_srcb_q;
    out_instr_d = out_instr_q;
    out_rd_d    = out_rd_q;
    out_ctl_d   = out_ctl_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (issue) begin
      out_valid_d = 1'b1;
      out_pc_d    = head_pc;
      out_srca_d  = srca;
      out_srcb_d  = srcb;
      out_instr_d = head_instr;
      out_rd_d    = head_instr[11:7];
      out_ctl_d   = head_ctl;
    end else if (io.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_srca_q  <= '0;
      out_srcb_q  <= '0;
      out_instr_q <= '0;
      out_rd_q    <= '0;
      out_ctl_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_srca_q  <= out_srca_d;
      out_srcb_q  <= out_srcb_d;
      out_instr_q <= out_instr_d;
      out_rd_q    <= out_rd_d;
      out_ctl_q   <= out_ctl_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_pc    = out_pc_q;
  assign io.out_srca  = out_srca_q;
  assign io.out_srcb  = out_srcb_q;
  assign io.out_instr = out_instr_q;
  assign io.out_rd    = out_rd_q;
  assign io.out_ctl   = out_ctl_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Self-checking bench for decode_stage: directed scenarios plus random
//   traffic, checked every cycle against a queue-based reference model.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam int NBYP  = 2;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(XLEN)) bus ();

  creg_addr_t             rs1, rs2;
  logic [XLEN-1:0]        rd1, rd2;
  logic [NBYP-1:0]        byp_valid, byp_pending;
  logic [NBYP*5-1:0]      byp_rd;
  logic [NBYP*XLEN-1:0]   byp_data;
  logic                   flush;
  logic [XLEN-1:0]        rf [32];

  assign rd1 = rf[rs1];
  assign rd2 = rf[rs2];

  decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .NBYP(NBYP)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .io          (bus),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd1         (rd1),
    .rd2         (rd2),
    .byp_valid   (byp_valid),
    .byp_rd      (byp_rd),
    .byp_data    (byp_data),
    .byp_pending (byp_pending),
    .flush       (flush)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic        m_ov;
  logic [63:0] m_pc, m_srca, m_srcb;
  logic [31:0] m_instr;

  function automatic bit is_itype(input logic [31:0] i);
    return i[6:0] inside {7'h13, 7'h1b, 7'h03, 7'h67};
  endfunction
  function automatic bit reads_rs1(input logic [31:0] i);
    return i[6:0] inside {7'h33, 7'h3b, 7'h13, 7'h1b, 7'h03, 7'h67, 7'h23, 7'h63};
  endfunction
  function automatic bit reads_rs2(input logic [31:0] i);
    return i[6:0] inside {7'h33, 7'h3b, 7'h23, 7'h63};
  endfunction

  task automatic resolve(input logic [4:0] a, output logic [63:0] v, output bit pend);
    v    = '0;
    pend = 1'b0;
    if (a != 5'd0) begin
      v = rf[a];
      for (int i = NBYP - 1; i >= 0; i--) begin
        if (byp_valid[i] && byp_rd[i*5 +: 5] == a) begin
          v    = byp_data[i*XLEN +: XLEN];
          pend = byp_pending[i];
        end
      end
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ov    = 1'b0;
    m_pc    = '0;
    m_srca  = '0;
    m_srcb  = '0;
    m_instr = '0;
  endtask

  // Called at a negedge with inputs already applied; checks, advances the
  // model across the coming posedge and returns at the next negedge.
  task automatic cycle();
    ent_t        h;
    bit          have, pa, pb, hz, iss, psh;
    logic [4:0]  e1, e2;
    logic [63:0] va, vb;
    #1;
    have = (mq.size() > 0);
    if (have) h = mq[0];
    e1 = have ? h.instr[19:15] : 5'd0;
    e2 = (have && !is_itype(h.instr)) ? h.instr[24:20] : 5'd0;
    check_eq("in_ready",  bus.in_ready, mq.size() < DEPTH);
    check_eq("rs1",       rs1, e1);
    check_eq("rs2",       rs2, e2);
    check_eq("out_valid", bus.out_valid, m_ov);
    check_eq("out_pc",    bus.out_pc, m_pc);
    check_eq("out_instr", bus.out_instr, m_instr);
    check_eq("out_rd",    bus.out_rd, m_instr[11:7]);
    check_eq("out_srca",  bus.out_srca, m_srca);
    check_eq("out_srcb",  bus.out_srcb, m_srcb);
    if (m_ov) begin
      check_eq("ctl_use1", bus.out_ctl.use_rs1, reads_rs1(m_instr));
      check_eq("ctl_use2", bus.out_ctl.use_rs2, reads_rs2(m_instr));
    end
    resolve(e1, va, pa);
    resolve(e2, vb, pb);
    hz  = have && ((reads_rs1(h.instr) && pa) || (reads_rs2(h.instr) && pb));
    iss = have && !hz && (!m_ov || bus.out_ready);
    psh = bus.in_valid && (mq.size() < DEPTH);
    if (flush) begin
      mq.delete();
      m_ov = 1'b0;
    end else begin
      if (iss) begin
        m_ov    = 1'b1;
        m_pc    = h.pc;
        m_instr = h.instr;
        m_srca  = va;
        m_srcb  = vb;
        void'(mq.pop_front());
      end else if (m_ov && bus.out_ready) begin
        m_ov = 1'b0;
      end
      if (psh) mq.push_back('{bus.in_pc, bus.in_instr});
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    return {7'd0, b, a, 3'd0, rd, 7'h33};
  endfunction
  function automatic logic [31:0] mk_i(input logic [4:0] rd, input logic [4:0] a, input logic [11:0] imm);
    return {imm, a, 3'd0, rd, 7'h13};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: r[6:0] = 7'h13;
      1: r[6:0] = 7'h33;
      2: r[6:0] = 7'h03;
      3: r[6:0] = 7'h23;
      4: r[6:0] = 7'h63;
      5: r[6:0] = 7'h37;
      default: r[6:0] = 7'h6f;
    endcase
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  task automatic set_idle();
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b1;
    byp_valid     = '0;
    byp_pending   = '0;
    byp_rd        = '0;
    byp_data      = '0;
    flush         = 1'b0;
  endtask

  task automatic randomize_inputs();
    bus.in_valid  = ($urandom_range(0, 3) != 0);
    bus.in_pc     = {$urandom, $urandom};
    bus.in_instr  = rand_instr();
    bus.out_ready = ($urandom_range(0, 3) != 0);
    flush         = ($urandom_range(0, 49) == 0);
    for (int i = 0; i < NBYP; i++) begin
      byp_valid[i]          = 1'($urandom_range(0, 1));
      byp_rd[i*5 +: 5]      = 5'($urandom_range(0, 7));
      byp_data[i*XLEN +: XLEN] = {$urandom, $urandom};
      byp_pending[i]        = ($urandom_range(0, 5) == 0);
    end
  endtask

  task automatic push_cycle(input logic [63:0] pc, input logic [31:0] instr);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_instr = instr;
    cycle();
    bus.in_valid = 1'b0;
  endtask

  logic [63:0] drained[$];

  initial begin
    resetn = 1'b0;
    set_idle();
    model_reset();
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
    rf[5] = 64'h33;

    // reset values
    #2;
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_in_ready",  bus.in_ready, 1'b1);
    check_eq("rst_out_pc",    bus.out_pc, 64'd0);
    check_eq("rst_out_srca",  bus.out_srca, 64'd0);
    check_eq("rst_out_srcb",  bus.out_srcb, 64'd0);
    check_eq("rst_out_instr", bus.out_instr, 64'd0);
    check_eq("rst_out_rd",    bus.out_rd, 64'd0);
    check_eq("rst_out_ctl",   64'(bus.out_ctl), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // streaming: addi then add back-to-back
    push_cycle(64'h1000, mk_i(5'd5, 5'd0, 12'd7));
    check_eq("addi_rs2", rs2, 5'd0);
    push_cycle(64'h1004, mk_r(5'd6, 5'd5, 5'd5));
    check_eq("stream_v0", bus.out_valid, 1'b1);
    check_eq("stream_i0", bus.out_instr, 32'h00700293);
    cycle();
    check_eq("stream_v1", bus.out_valid, 1'b1);
    check_eq("stream_i1", bus.out_instr, 32'h00528333);
    cycle();

    // bypass priority
    set_idle();
    byp_valid = 2'b11;
    byp_rd    = {5'd5, 5'd5};
    byp_data  = {64'h22, 64'h11};
    push_cycle(64'h1100, mk_r(5'd6, 5'd5, 5'd5));
    cycle();
    check_eq("byp0_wins", bus.out_srca, 64'h11);
    byp_valid = 2'b10;
    push_cycle(64'h1104, mk_r(5'd6, 5'd5, 5'd5));
    cycle();
    check_eq("byp1_used", bus.out_srca, 64'h22);
    push_cycle(64'h1108, mk_r(5'd6, 5'd0, 5'd5));
    cycle();
    check_eq("x0_src", bus.out_srca, 64'd0);
    check_eq("x0_srcb", bus.out_srcb, 64'h22);

    // load-use stall
    set_idle();
    cycle();
    byp_valid   = 2'b01;
    byp_rd      = {5'd0, 5'd5};
    byp_data    = {64'h0, 64'h55};
    byp_pending = 2'b01;
    push_cycle(64'h1200, mk_r(5'd6, 5'd5, 5'd0));
    for (int k = 0; k < 3; k++) begin
      if (k == 1) check_eq("lu_in_ready", bus.in_ready, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_pc    = 64'h1204 + 64'(4 * k);
      bus.in_instr = mk_i(5'd7, 5'd1, 12'd3);
      cycle();
      check_eq("lu_stall", bus.out_valid, 1'b0);
    end
    bus.in_valid = 1'b0;
    byp_pending  = 2'b00;
    cycle();
    check_eq("lu_issue", bus.out_valid, 1'b1);
    check_eq("lu_srca",  bus.out_srca, 64'h55);
    check_eq("lu_pc",    bus.out_pc, 64'h1200);
    for (int k = 0; k < 3; k++) cycle();

    // backpressure then in-order drain
    set_idle();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_cycle(64'h2000 + 64'(4 * k), mk_i(5'(k + 1), 5'd2, 12'(k)));
    check_eq("bp_in_ready", bus.in_ready, 1'b0);
    check_eq("bp_hold_pc",  bus.out_pc, 64'h2000);
    bus.out_ready = 1'b1;
    drained.delete();
    for (int k = 0; k < 5; k++) begin
      if (bus.out_valid) drained.push_back(bus.out_pc);
      cycle();
    end
    check_eq("bp_count", drained.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < drained.size()) check_eq("bp_order", drained[k], 64'h2000 + 64'(4 * k));
    end

    // flush with full buffer and valid output
    set_idle();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_cycle(64'h3000 + 64'(4 * k), mk_i(5'd3, 5'd4, 12'd1));
    check_eq("fl_pre_valid", bus.out_valid, 1'b1);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pc    = 64'h3100;
    bus.in_instr = mk_i(5'd9, 5'd0, 12'd9);
    cycle();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check_eq("fl_out_valid", bus.out_valid, 1'b0);
    check_eq("fl_in_ready",  bus.in_ready, 1'b1);
    cycle();
    cycle();
    check_eq("fl_dropped", bus.out_valid, 1'b0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      cycle();
    end

    // reset mid-stream with entries held
    set_idle();
    cycle();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_cycle(64'h4000 + 64'(4 * k), mk_r(5'd1, 5'd2, 5'd3));
    check_eq("mr_pre_full", bus.in_ready, 1'b0);
    resetn = 1'b0;
    #1;
    check_eq("mr_out_valid", bus.out_valid, 1'b0);
    check_eq("mr_in_ready",  bus.in_ready, 1'b1);
    check_eq("mr_out_pc",    bus.out_pc, 64'd0);
    check_eq("mr_out_instr", bus.out_instr, 64'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    set_idle();
    for (int k = 0; k < 4; k++) cycle();
    check_eq("mr_no_stale", bus.out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL take parameters (name, default, meaning):
- XLEN, 64, datapath width
- DEPTH, 2, instruction-buffer entries (power of two, >=2)
- NBYP, 2, bypass sources; index 0 = youngest/highest priority
REQ-002 SHALL have these ports (name direction width meaning):
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  buffer can accept
- in_pc  in  XLEN  fetched pc
- in_instr  in  32  raw instruction
- rs1, rs2  out  5  regfile read addresses
- rd1, rd2  in  XLEN  regfile read data, combinational
- byp_valid  in  NBYP  bypass entry live
- byp_rd  in  NBYP*5  bypass destination register
- byp_data  in  NBYP*XLEN  bypass result
- byp_pending  in  NBYP  result not yet available (load in flight)
- flush  in  1  discard all held instructions
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts
- out_pc, out_srca, out_srcb  out  XLEN each  pc, operand A, operand B
- out_instr  out  32  raw instruction
- out_rd  out  5  instr[11:7]
- out_ctl  out  control_t  decoder control

Function
REQ-003 SHALL accept in_instr/in_pc into a FIFO on clk edge when in_valid and in_ready; in_ready = entry count < DEPTH (no same-cycle pop credit when full).
REQ-004 SHALL decode FIFO head combinationally; rs1 = head[19:15]; rs2 = 0 when ctl.op is ITYPE, else head[24:20]; both 0 when FIFO empty.
REQ-005 Per operand: if address is 0, operand = 0 and never hazards; else lowest-index bypass with byp_valid and matching byp_rd wins; else rd1/rd2.
REQ-006 Hazard SHALL be asserted when the winning bypass for either used operand has byp_pending set.
REQ-007 Issue SHALL occur when head valid, no hazard, and (out_valid == 0 or out_ready); on issue the output register loads the bundle, out_valid = 1, head pops.
REQ-008 When out_valid and not out_ready, all out_* SHALL hold stable.
REQ-009 When out_valid, out_ready and no issue, out_valid SHALL clear next cycle.
REQ-010 Minimum latency: accepted at edge t into empty buffer -> out_valid at edge t+1; throughput 1/cycle without hazards.
REQ-011 Simultaneous push and pop with count < DEPTH SHALL keep count unchanged; pointers wrap modulo DEPTH.
REQ-012 flush SHALL, at the next edge, empty the FIFO, clear out_valid and ignore any push or issue that cycle; flush has priority over all events.

Reset
REQ-013 On resetn low, immediately: FIFO empty, pointers 0, out_valid 0, out_pc/out_srca/out_srcb/out_instr/out_rd/out_ctl 0; in_ready 1 after release.
REQ-014 Reset mid-operation SHALL discard all held instructions with no partial output.

Structure
REQ-015 fetch_data_t, decode_data_t, control_t, creg_addr_t, word_t and op encodings SHALL live in the shared pipes/common packages; NBYP/DEPTH defaults as package constants.
REQ-016 The FIFO SHALL be one sub-module, ibuf (parametrised XLEN+32 width, DEPTH); the existing decoder is instanced unchanged.

Verification
REQ-017 Reset: hold resetn low mid-stream with 2 entries held -> out_valid 0, in_ready 1 after release, no stale output.
REQ-018 Streaming: push addi x5,x0,7 then add x6,x5,x5 back-to-back, out_ready=1 -> outputs on consecutive cycles, rs2 = 0 for addi.
REQ-019 Bypass priority: byp0 rd=5 data=0x11, byp1 rd=5 data=0x22, rd1=0x33 -> out_srca = 0x11; disable byp0 -> 0x22; x0 source -> 0.
REQ-020 Load-use: byp0 rd=5 pending=1 for 3 cycles -> no issue 3 cycles, in_ready low once DEPTH=2 full; pending drops -> issue with byp_data.
REQ-021 Backpressure: out_ready=0 for 4 cycles -> out_* stable, FIFO fills, in_ready 0; out_ready=1 -> drain in order, no loss/duplication.
REQ-022 Flush: flush with full FIFO, out_valid=1, in_valid=1 -> next cycle count 0, out_valid 0, pushed instruction dropped.
